// File: rtl/percent_to_value_pkg.sv
// rtl/percent_to_value_pkg.sv - shared constants and handshake state encoding for the percentage blocks
package percent_to_value_pkg;

    localparam int PCT_DIVISOR = 100;
    localparam int PCT_VAL_W   = 20;
    localparam int PCT_PCT_W   = 7;

    // Common go/done FSM encoding, so one controller sees identical codes from both blocks
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } pct_state_e;

endpackage

// File: rtl/percent_to_value_if.sv
// rtl/percent_to_value_if.sv - go/done request bus between a controller and percent_to_value
interface percent_to_value_if
    import percent_to_value_pkg::*;
#(
    parameter int VAL_W = PCT_VAL_W,
    parameter int PCT_W = PCT_PCT_W,
    parameter int REM_W = $clog2(PCT_DIVISOR)
);
    logic             go;
    logic [VAL_W-1:0] full_scale;
    logic [PCT_W-1:0] percent;
    logic [VAL_W:0]   value;
    logic [REM_W-1:0] remainder;
    logic             done;

    modport master (
        output go, full_scale, percent,
        input  value, remainder, done
    );

    modport slave (
        input  go, full_scale, percent,
        output value, remainder, done
    );

endinterface

// File: rtl/percent_to_value.sv
// rtl/percent_to_value.sv - value = floor(full_scale * percent / DIVISOR) by serial restoring division
module percent_to_value
    import percent_to_value_pkg::*;
#(
    parameter int VAL_W   = PCT_VAL_W,
    parameter int PCT_W   = PCT_PCT_W,
    parameter int DIVISOR = PCT_DIVISOR,
    parameter int ROUND   = 0
) (
    input  logic              clk,
    input  logic              reset,
    percent_to_value_if.slave bus
);

    localparam int P     = VAL_W + PCT_W;
    localparam int REM_W = $clog2(DIVISOR);
    localparam int PR_W  = REM_W + 1;
    localparam int CNT_W = $clog2(P);

    localparam logic [P-1:0]    RND_OFS = (ROUND != 0) ? P'(DIVISOR / 2) : '0;
    localparam logic [PR_W-1:0] DIV_K   = PR_W'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(P - 1);

    // The quotient only fits VAL_W+1 bits when the largest percent stays below twice the divisor
    generate
        if (((2 ** PCT_W) - 1) >= 2 * DIVISOR) begin : g_width_chk
            $error("percent_to_value: PCT_W too wide for DIVISOR, quotient would overflow VAL_W+1 bits");
        end
    endgenerate

    pct_state_e       state_q, state_d;
    logic [P-1:0]     prod_q, prod_d;
    logic [P-1:0]     quot_q, quot_d;
    logic [PR_W-1:0]  part_q, part_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VAL_W:0]   value_q, value_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    logic [P-1:0]     product;
    logic [PR_W-1:0]  part_sh;
    logic [PR_W-1:0]  part_nx;
    logic             q_bit;
    logic [P-1:0]     quot_nx;

    // Full-width product (plus rounding offset) formed only for the capture edge
    assign product = (P'(bus.full_scale) * P'(bus.percent)) + RND_OFS;

    // State, datapath and result registers; reset discards any division in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prod_q  <= '0;
            quot_q  <= '0;
            part_q  <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            quot_q  <= quot_d;
            part_q  <= part_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    // One restoring-division step: bring in the next product bit MSB first, subtract when it fits
    always_comb begin
        part_sh = {part_q[PR_W-2:0], prod_q[cnt_q]};
        q_bit   = (part_sh >= DIV_K);
        part_nx = q_bit ? (part_sh - DIV_K) : part_sh;
        quot_nx = {quot_q[P-2:0], q_bit};
    end

    // Handshake FSM: capture on go, run exactly P steps, hold the result until go drops
    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        quot_d  = quot_q;
        part_d  = part_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        rem_d   = rem_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                if (bus.go) begin
                    prod_d  = product;
                    cnt_d   = CNT_TOP;
                    part_d  = '0;
                    quot_d  = '0;
                    state_d = DIV;
                end
            end
            DIV: begin
                part_d = part_nx;
                quot_d = quot_nx;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    value_d = quot_nx[VAL_W:0];
                    rem_d   = part_nx[REM_W-1:0];
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!bus.go) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.value     = value_q;
    assign bus.remainder = rem_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_percent_to_value.sv
// tb/tb_percent_to_value.sv - scoreboard bench for percent_to_value (truncating and rounding instances)
module tb_percent_to_value;

    localparam int LAT = 27;

    logic clk;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        logic [20:0] v;
        logic [6:0]  r;
        int          at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic prev0;
    logic prev1;

    percent_to_value_if #(.VAL_W(20), .PCT_W(7), .REM_W(7)) bus0 ();
    percent_to_value_if #(.VAL_W(20), .PCT_W(7), .REM_W(7)) bus1 ();

    percent_to_value #(.VAL_W(20), .PCT_W(7), .DIVISOR(100), .ROUND(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    percent_to_value #(.VAL_W(20), .PCT_W(7), .DIVISOR(100), .ROUND(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_done(input int inst);
        return (inst == 0) ? bus0.done : bus1.done;
    endfunction

    function automatic logic [20:0] get_value(input int inst);
        return (inst == 0) ? bus0.value : bus1.value;
    endfunction

    task automatic drive(input int inst, input logic g, input logic [19:0] fs, input logic [6:0] pct);
        if (inst == 0) begin
            bus0.go = g; bus0.full_scale = fs; bus0.percent = pct;
        end else begin
            bus1.go = g; bus1.full_scale = fs; bus1.percent = pct;
        end
    endtask

    task automatic push(input int inst, input logic [20:0] ev, input logic [6:0] er);
        exp_t e;
        e.v = ev; e.r = er; e.at = cyc + 1 + LAT;
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic set_go(input int inst, input logic g);
        if (inst == 0) bus0.go = g;
        else           bus1.go = g;
    endtask

    // Waits for done after a request is already issued, then runs the release half of the handshake
    task automatic finish_op(input int inst, input logic [20:0] ev, input int hold, input bit early);
        int t;
        t = 0;
        while (!get_done(inst) && t < 80) begin
            @(negedge clk);
            t++;
        end
        if (!get_done(inst)) begin
            chk("done_timeout", 0, 1);
            set_go(inst, 1'b0);
            repeat (3) @(negedge clk);
        end else if (early) begin
            @(negedge clk);
            chk("done_single_pulse", 32'(get_done(inst)), 0);
        end else begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("done_held", 32'(get_done(inst)), 1);
                chk("value_held", 32'(get_value(inst)), 32'(ev));
            end
            set_go(inst, 1'b0);
            @(negedge clk);
            chk("done_low_after_go", 32'(get_done(inst)), 0);
        end
    endtask

    task automatic op(input int inst, input logic [19:0] fs, input logic [6:0] pct,
                      input logic [20:0] ev, input logic [6:0] er, input int hold, input bit early);
        @(negedge clk);
        drive(inst, 1'b1, fs, pct);
        push(inst, ev, er);
        if (early) begin
            repeat (5) @(negedge clk);
            set_go(inst, 1'b0);
            drive(inst, 1'b0, 20'hABCDE, 7'd3);
        end
        finish_op(inst, ev, hold, early);
    endtask

    // Monitor: every rising done is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus0.done && !prev0) begin
            if (q0.size() == 0) begin
                chk("unexpected_done0", 1, 0);
            end else begin
                e = q0.pop_front();
                chk("value0", 32'(bus0.value), 32'(e.v));
                chk("remainder0", 32'(bus0.remainder), 32'(e.r));
                chk("latency0", 32'(cyc), 32'(e.at));
            end
        end
        if (bus1.done && !prev1) begin
            if (q1.size() == 0) begin
                chk("unexpected_done1", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("value1", 32'(bus1.value), 32'(e.v));
                chk("remainder1", 32'(bus1.remainder), 32'(e.r));
                chk("latency1", 32'(cyc), 32'(e.at));
            end
        end
        prev0 = bus0.done;
        prev1 = bus1.done;
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        prev0   = 1'b0;
        prev1   = 1'b0;
        reset   = 1'b1;
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("reset_done0", 32'(bus0.done), 0);
        chk("reset_value0", 32'(bus0.value), 0);
        chk("reset_rem0", 32'(bus0.remainder), 0);
        chk("reset_done1", 32'(bus1.done), 0);
        chk("reset_value1", 32'(bus1.value), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        op(0, 20'd1000,    7'd25,  21'd250,     7'd0,  10, 1'b0);
        op(0, 20'd7,       7'd50,  21'd3,       7'd50, 0,  1'b0);
        op(0, 20'd1048575, 7'd127, 21'd1331690, 7'd25, 1,  1'b0);
        op(0, 20'd500,     7'd0,   21'd0,       7'd0,  0,  1'b0);
        op(0, 20'd0,       7'd99,  21'd0,       7'd0,  0,  1'b0);
        op(0, 20'd300,     7'd40,  21'd120,     7'd0,  0,  1'b1);
        op(0, 20'd123,     7'd45,  21'd55,      7'd35, 2,  1'b0);

        op(1, 20'd7,       7'd50,  21'd4,       7'd0,  0,  1'b0);
        op(1, 20'd3,       7'd50,  21'd2,       7'd0,  0,  1'b0);
        op(1, 20'd1000,    7'd25,  21'd250,     7'd50, 0,  1'b0);
        op(1, 20'd1048575, 7'd127, 21'd1331690, 7'd75, 0,  1'b0);

        // Abort a division with an asynchronous reset, then restart straight out of reset
        @(negedge clk);
        drive(0, 1'b1, 20'd1000, 7'd25);
        repeat (10) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("abort_done", 32'(bus0.done), 0);
        chk("abort_value", 32'(bus0.value), 0);
        chk("abort_rem", 32'(bus0.remainder), 0);
        @(negedge clk);
        drive(0, 1'b1, 20'd200, 7'd75);
        reset = 1'b0;
        push(0, 21'd150, 7'd0);
        finish_op(0, 21'd150, 1, 1'b0);

        repeat (5) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
